// File: rtl/duty_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// duty_ramp_ctrl
//
// Purpose:
//   Slew-rate limiter for a PWM duty value. A free-running R-bit counter
//   defines a PWM period of 2**R clocks. A requested target duty is accepted
//   while idle. The output duty then moves toward it by at most STEP per
//   period. Duty only changes on the edge where the counter wraps to 0, so
//   the downstream PWM never sees a mid-period duty change.
//
// Parameters:
//   R     - duty / period counter width (period = 2**R clocks)
//   STEP  - maximum duty change per period (1 .. 2**R-1)
//   DMAX  - target ceiling, only honoured when DUTY_RAMP_CLAMP_EN is defined
//
// Optional feature macro:
//   DUTY_RAMP_CLAMP_EN - when defined, an accepted target is clamped to DMAX.
//                        When undefined, the target is latched unmodified.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   tgt_duty     in   [R-1:0] requested target duty
//   tgt_valid    in   target request strobe
//   tgt_ready    out  high while idle (a request is accepted this cycle)
//   duty         out  [R-1:0] registered duty for the PWM
//   busy         out  high while ramping
//   period_tick  out  registered pulse during the last clock of each period
// -----------------------------------------------------------------------------
module duty_ramp_ctrl #(
    parameter int R    = 8,
    parameter int STEP = 1,
    parameter int DMAX = 2**R - 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [R-1:0] tgt_duty,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    output logic [R-1:0] duty,
    output logic         busy,
    output logic         period_tick
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam logic [R-1:0] CNT_MAX = {R{1'b1}};
    localparam logic [R:0]   STEP_W  = (R+1)'(STEP);

    state_t       state_q,  state_d;
    logic [R-1:0] cnt_q,    cnt_d;
    logic         tick_q,   tick_d;
    logic [R-1:0] duty_q,   duty_d;
    logic [R-1:0] target_q, target_d;

    logic [R-1:0] lat_duty;
    logic         boundary;
    logic [R:0]   up_sum;
    logic [R:0]   dn_diff;
    logic [R:0]   tgt_w;
    logic [R-1:0] ramp_next;

    // Value that would be latched as the new target on acceptance.
`ifdef DUTY_RAMP_CLAMP_EN
    localparam logic [R-1:0] DMAX_W = R'(DMAX);
    always_comb lat_duty = (tgt_duty > DMAX_W) ? DMAX_W : tgt_duty;
`else
    always_comb lat_duty = tgt_duty;
`endif

    // The period boundary is the edge on which cnt wraps to 0.
    assign boundary = (cnt_q == CNT_MAX);

    // One extra bit so the step can neither overflow past 2**R-1 nor
    // underflow below 0. Any underflow shows up as bit R set in dn_diff.
    assign up_sum  = {1'b0, duty_q} + STEP_W;
    assign dn_diff = {1'b0, duty_q} - STEP_W;
    assign tgt_w   = {1'b0, target_q};

    always_comb begin
        ramp_next = target_q;
        if (target_q > duty_q) begin
            ramp_next = (up_sum >= tgt_w) ? target_q : up_sum[R-1:0];
        end else if (target_q < duty_q) begin
            ramp_next = (dn_diff[R] || (dn_diff <= tgt_w)) ? target_q : dn_diff[R-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        cnt_d    = cnt_q + R'(1);
        // Registered tick: high during the clock in which cnt_q == CNT_MAX.
        tick_d   = (cnt_d == CNT_MAX);

        case (state_q)
            ST_IDLE: begin
                // No step is applied on the acceptance edge, even when it
                // coincides with a boundary. Ramping starts at the next one.
                if (tgt_valid) begin
                    target_d = lat_duty;
                    if (lat_duty != duty_q) begin
                        state_d = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (boundary) begin
                    duty_d = ramp_next;
                    if (ramp_next == target_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            duty_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            duty_q   <= duty_d;
            target_q <= target_d;
        end
    end

    assign tgt_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_RAMP);
    assign duty        = duty_q;
    assign period_tick = tick_q;

endmodule

// File: doc/duty_ramp_ctrl.md
DUTY_RAMP_CTRL -- requirements
Module: duty_ramp_ctrl

Interface
REQ-001 SHALL have parameter R, default 8, meaning duty/counter width; the PWM period is 2**R clocks.
REQ-002 SHALL have parameter STEP, default 1, meaning the maximum duty change per PWM period (1..2**R-1).
REQ-003 SHALL have parameter DMAX, default 2**R-1, meaning the target clamp ceiling (used only per REQ-026).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have port tgt_duty, input, R bits, the requested target duty.
REQ-007 SHALL have port tgt_valid, input, 1 bit, target request strobe.
REQ-008 SHALL have port tgt_ready, output, 1 bit, target acceptance; high only in IDLE.
REQ-009 SHALL have port duty, output, R bits, registered duty that drives the downstream PWM duty input.
REQ-010 SHALL have port busy, output, 1 bit, high while in RAMP.
REQ-011 SHALL have port period_tick, output, 1 bit, registered one-clock pulse at the end of each PWM period.

Function
REQ-012 SHALL hold a free-running R-bit period counter cnt: +1 every clock, wrapping 2**R-1 -> 0.
REQ-013 SHALL assert period_tick for exactly the clock in which cnt==2**R-1.
REQ-014 SHALL define the period boundary as the clock edge on which cnt wraps to 0; duty SHALL change only on that edge, so a new duty is valid from the cycle in which cnt==0.
REQ-015 SHALL implement two states, IDLE and RAMP, and drive tgt_ready = (state==IDLE) and busy = (state==RAMP).
REQ-016 SHALL accept a target on an edge where tgt_valid && tgt_ready: latch it into an internal target register; next state RAMP if the latched value != duty, else stay in IDLE.
REQ-017 SHALL ignore tgt_valid while in RAMP, with no latching and no side effect.
REQ-018 SHALL, in RAMP at each period boundary, set duty to min(duty+STEP, target) if duty<target, or to max(duty-STEP, target) if duty>target.
REQ-019 SHALL compute the ramp arithmetic at R+1 bits, so that duty never wraps past 2**R-1 or below 0.
REQ-020 SHALL move to IDLE on the same edge at which duty becomes equal to target; busy SHALL deassert in the following cycle.
REQ-021 SHALL, on an acceptance edge that coincides with a period boundary, apply no step on that edge; ramping SHALL begin at the next boundary.
REQ-022 SHALL give a ramp from duty d to target t a latency of ceil(|t-d|/STEP) period boundaries.

Reset
REQ-023 SHALL, while reset_n=0, immediately force cnt=0, duty=0, target=0, state=IDLE, period_tick=0, busy=0, tgt_ready=1.
REQ-024 SHALL treat reset_n assertion mid-ramp as an abort: duty SHALL return to 0 immediately and no ramp state SHALL be retained.
REQ-025 SHALL resume counting from cnt=0 on the first rising edge after reset_n deasserts.

Configuration
REQ-026 SHALL, with macro DUTY_RAMP_CLAMP_EN defined, latch min(tgt_duty, DMAX) as target; without the macro, SHALL latch tgt_duty unmodified and ignore DMAX.

Verification
REQ-027 SHALL cover (R=8, STEP=16): reset, then target 64 -> duty steps 16, 32, 48, 64 on four consecutive boundaries, each first seen at cnt==0; busy low after the step to 64.
REQ-028 SHALL cover (STEP=16): from duty 64, target 70 -> duty 70 after one boundary; then target 0 -> duty 54, 38, 22, 6, 0 over five boundaries.
REQ-029 SHALL cover saturation (STEP=16): from duty 250, target 255 -> duty 255 with no wrap; then target 3 from 10 -> duty 3, never negative.
REQ-030 SHALL cover the handshake: tgt_valid=1 with tgt_duty=200 during RAMP -> tgt_ready=0 and target unchanged; the same request issued in IDLE -> accepted in one cycle.
REQ-031 SHALL cover reset mid-ramp: reset_n pulsed low at duty 32 of a 0->128 ramp -> duty=0, busy=0 immediately, cnt restarts at 0.
REQ-032 SHALL cover the configuration: with DUTY_RAMP_CLAMP_EN and DMAX=200, target 255 -> duty settles at 200; without the macro, duty settles at 255.
